// File: rtl/opb_gpio_pkg.sv
// Shared constants for the OPB GPIO block with edge interrupts:
// register addresses decoded from OPB_ADDR[3:0] and parameter defaults.
package opb_gpio_pkg;

  localparam int DEF_N_IN      = 32;
  localparam int DEF_N_OUT     = 32;
  localparam int DEF_DB_CYCLES = 16;

  localparam logic [3:0] ADDR_IN       = 4'h0;
  localparam logic [3:0] ADDR_OUT      = 4'h1;
  localparam logic [3:0] ADDR_OUT_SET  = 4'h2;
  localparam logic [3:0] ADDR_OUT_CLR  = 4'h3;
  localparam logic [3:0] ADDR_RISE_EN  = 4'h4;
  localparam logic [3:0] ADDR_FALL_EN  = 4'h5;
  localparam logic [3:0] ADDR_IRQ_STAT = 4'h6;
  localparam logic [3:0] ADDR_IRQ_MASK = 4'h7;

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit debounce filter. The held value flips only after the input
// has disagreed with it for DB_CYCLES consecutive edges; any agreeing
// edge restarts the count. q is the value the filter will hold after the
// coming edge, so the parent registers q and can detect the edge of the
// filtered signal on the very edge it changes.
module gpio_debounce
  import opb_gpio_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             state_reg;
  logic             state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Count consecutive disagreeing edges; flip the held value on the last one.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    if (d != state_reg) begin
      if (cnt_reg == CNT_LAST) begin
        state_next = d;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Filter state; reset discards any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign q = state_next;

endmodule

// File: rtl/opb_gpio_irq.sv
// OPB GPIO peripheral with synchronised inputs, optional debounce and
// per-bit rise/fall edge interrupts.
// Build option: define OPB_GPIO_DEBOUNCE_EN to insert a gpio_debounce
// filter per input; otherwise the filtered value follows the synchroniser.
module opb_gpio_irq
  import opb_gpio_pkg::*;
#(
  parameter int N_IN      = DEF_N_IN,
  parameter int N_OUT     = DEF_N_OUT,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic             OPB_CLK,
  input  logic             OPB_RST,
  input  logic [31:0]      OPB_DI,
  output logic [31:0]      OPB_DO,
  input  logic [31:0]      OPB_ADDR,
  input  logic             GPIO_RE,
  input  logic             GPIO_WE,
  input  logic [N_IN-1:0]  GPIO_I,
  output logic [N_OUT-1:0] GPIO_O,
  output logic             GPIO_IRQ
);
  logic [3:0]       addr;
  logic [N_IN-1:0]  s1_reg, s2_reg, f_reg, f_next;
  logic [N_IN-1:0]  rise_en_reg, fall_en_reg, mask_reg;
  logic [N_IN-1:0]  stat_reg, stat_next, stat_clr;
  logic [N_IN-1:0]  rise, fall, wdata_in;
  logic [N_OUT-1:0] out_reg, out_next, wdata_out;
  logic [31:0]      rdata;
  logic [31:0]      do_reg;
  logic             irq_reg;
  logic             unused_bits;

  assign addr        = OPB_ADDR[3:0];
  assign wdata_in    = OPB_DI[N_IN-1:0];
  assign wdata_out   = OPB_DI[N_OUT-1:0];
  assign unused_bits = ^{OPB_ADDR[31:4], OPB_DI};

`ifdef OPB_GPIO_DEBOUNCE_EN
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_debounce
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk(OPB_CLK),
      .rst(OPB_RST),
      .d  (s2_reg[gi]),
      .q  (f_next[gi])
    );
  end
`else
  logic [31:0] unused_db;
  assign unused_db = 32'(DB_CYCLES);
  assign f_next    = s2_reg;
`endif

  // Two-flop synchroniser followed by the filtered-value register.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      s1_reg <= '0;
      s2_reg <= '0;
      f_reg  <= '0;
    end else begin
      s1_reg <= GPIO_I;
      s2_reg <= s1_reg;
      f_reg  <= f_next;
    end
  end

  // Edge events on the edge where the filtered value changes.
  assign rise = ~f_reg & f_next;
  assign fall = f_reg & ~f_next;

  // Next OUT value from replace / set / clear writes.
  always_comb begin
    out_next = out_reg;
    if (GPIO_WE) begin
      case (addr)
        ADDR_OUT:     out_next = wdata_out;
        ADDR_OUT_SET: out_next = out_reg | wdata_out;
        ADDR_OUT_CLR: out_next = out_reg & ~wdata_out;
        default:      out_next = out_reg;
      endcase
    end
  end

  // A W1C clear loses to an event arriving on the same edge.
  assign stat_clr  = (GPIO_WE && (addr == ADDR_IRQ_STAT)) ? wdata_in : '0;
  assign stat_next = (stat_reg & ~stat_clr) | (rise & rise_en_reg) | (fall & fall_en_reg);

  // Software-visible configuration registers.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      out_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      mask_reg    <= '0;
    end else begin
      out_reg <= out_next;
      if (GPIO_WE) begin
        case (addr)
          ADDR_RISE_EN:  rise_en_reg <= wdata_in;
          ADDR_FALL_EN:  fall_en_reg <= wdata_in;
          ADDR_IRQ_MASK: mask_reg    <= wdata_in;
          default:       ;
        endcase
      end
    end
  end

  // Interrupt status and the registered interrupt line one edge behind it.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      stat_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      stat_reg <= stat_next;
      irq_reg  <= |(stat_reg & mask_reg);
    end
  end

  // Read multiplexer; write-only and unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_IN:       rdata = 32'(f_reg);
      ADDR_OUT:      rdata = 32'(out_reg);
      ADDR_RISE_EN:  rdata = 32'(rise_en_reg);
      ADDR_FALL_EN:  rdata = 32'(fall_en_reg);
      ADDR_IRQ_STAT: rdata = 32'(stat_reg);
      ADDR_IRQ_MASK: rdata = 32'(mask_reg);
      default:       rdata = '0;
    endcase
  end

  // Registered read data, zero whenever no read strobe is present.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      do_reg <= '0;
    end else begin
      do_reg <= GPIO_RE ? rdata : 32'h0;
    end
  end

  assign OPB_DO   = do_reg;
  assign GPIO_O   = out_reg;
  assign GPIO_IRQ = irq_reg;

endmodule

// File: tb/tb_opb_gpio_irq.sv
// Bench for opb_gpio_irq: directed steps plus a randomised phase, all
// checked against a register-level model that derives the filtered input
// from a history of sampled pin values.
module tb_opb_gpio_irq;
  localparam int N_IN  = 8;
  localparam int N_OUT = 10;
  localparam int DB    = 16;
`ifdef OPB_GPIO_DEBOUNCE_EN
  localparam int EV_EDGE = 2 + DB;
  localparam int TOGGLE_ODDS = 20;
`else
  localparam int EV_EDGE = 3;
  localparam int TOGGLE_ODDS = 3;
`endif
  localparam logic [31:0] IN_MASK  = (32'd1 << N_IN) - 32'd1;
  localparam logic [31:0] OUT_MASK = (32'd1 << N_OUT) - 32'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      din, dout, addr;
  logic             re, we;
  logic [N_IN-1:0]  gi;
  logic [N_OUT-1:0] go;
  logic             irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]     out_m, ren_m, fen_m, stat_m, mask_m, f_m, do_m;
  logic            irq_m;
  logic [N_IN-1:0] hist[$];

  always #5 clk = ~clk;

  opb_gpio_irq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DB_CYCLES(DB)
  ) dut (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_DI(din), .OPB_DO(dout),
    .OPB_ADDR(addr), .GPIO_RE(re), .GPIO_WE(we), .GPIO_I(gi),
    .GPIO_O(go), .GPIO_IRQ(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [3:0] a);
    case (a)
      4'h0: return f_m;
      4'h1: return out_m;
      4'h4: return ren_m;
      4'h5: return fen_m;
      4'h6: return stat_m;
      4'h7: return mask_m;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    out_m = 0; ren_m = 0; fen_m = 0; stat_m = 0; mask_m = 0; f_m = 0;
    do_m = 0; irq_m = 1'b0;
    hist.delete();
  endtask

  // One clock edge of the model, using pre-edge state for reads and events.
  task automatic model_edge(input logic we_i, input logic re_i, input logic [3:0] a,
                            input logic [31:0] d, input logic [N_IN-1:0] pins);
    logic [31:0] f_new, ev, clr;
    int idx;
    logic v;
    bit all_diff;
    do_m  = re_i ? rd_model(a) : 32'h0;
    irq_m = |(stat_m & mask_m);
    hist.push_back(pins);
    if (hist.size() > DB + 8) void'(hist.pop_front());
    f_new = f_m;
    for (int b = 0; b < N_IN; b++) begin
`ifdef OPB_GPIO_DEBOUNCE_EN
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        idx = hist.size() - 3 - j;
        v = (idx >= 0) ? hist[idx][b] : 1'b0;
        if (v == f_m[b]) all_diff = 1'b0;
      end
      if (all_diff) f_new[b] = ~f_m[b];
`else
      idx = hist.size() - 3;
      v = (idx >= 0) ? hist[idx][b] : 1'b0;
      all_diff = 1'b0;
      f_new[b] = v;
`endif
    end
    ev  = ((~f_m & f_new & ren_m) | (f_m & ~f_new & fen_m)) & IN_MASK;
    clr = (we_i && a == 4'h6) ? (d & IN_MASK) : 32'h0;
    if (we_i) begin
      case (a)
        4'h1: out_m = d & OUT_MASK;
        4'h2: out_m = out_m | (d & OUT_MASK);
        4'h3: out_m = out_m & ~d;
        4'h4: ren_m = d & IN_MASK;
        4'h5: fen_m = d & IN_MASK;
        4'h7: mask_m = d & IN_MASK;
        default: ;
      endcase
    end
    stat_m = (stat_m & ~clr) | ev;
    f_m = f_new;
  endtask

  // One bus cycle: drive, clock, advance model, compare all outputs.
  task automatic step(input logic we_i, input logic re_i, input logic [3:0] a, input logic [31:0] d);
    we = we_i; re = re_i; din = d;
    addr = {28'($urandom()), a};
    @(posedge clk); #1;
    model_edge(we_i, re_i, a, d, gi);
    chk("do", dout, do_m);
    chk("gpio_o", 32'(go), out_m);
    chk("irq", 32'(irq), 32'(irq_m));
    we = 1'b0; re = 1'b0;
  endtask

  int k;

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; din = 0; addr = 0; gi = '0;
    model_reset();
    #12;
    chk("rst_do", dout, 32'h0);
    chk("rst_gpio_o", 32'(go), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(posedge clk); #3; rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, 4'(a), 32'h0);
      chk("rst_reg_read", dout, 32'h0);
    end

    // OUT replace / set / clear
    step(1'b1, 1'b0, 4'h1, 32'h0000_00F0);
    step(1'b1, 1'b0, 4'h2, 32'h0000_000F);
    step(1'b1, 1'b0, 4'h3, 32'h0000_0030);
    chk("set_clr_pins", 32'(go), 32'h0000_00CF);
    step(1'b0, 1'b1, 4'h1, 32'h0);
    chk("set_clr_read", dout, 32'h0000_00CF);

    // Width limits, unmapped / write-only / no-strobe reads
    step(1'b1, 1'b0, 4'h1, 32'hFFFF_FFFF);
    chk("out_width_pins", 32'(go), 32'h0000_03FF);
    step(1'b0, 1'b1, 4'h1, 32'h0);
    chk("out_width_read", dout, 32'h0000_03FF);
    step(1'b0, 1'b1, 4'hA, 32'h0);
    chk("unmapped_read", dout, 32'h0);
    step(1'b0, 1'b1, 4'h2, 32'h0);
    chk("wo_read", dout, 32'h0);
    step(1'b0, 1'b0, 4'h1, 32'h0);
    chk("no_re_read", dout, 32'h0);
    step(1'b1, 1'b0, 4'h4, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 4'h4, 32'h0);
    chk("rise_en_width", dout, 32'h0000_00FF);
    step(1'b1, 1'b0, 4'h0, 32'h0000_1234);
    step(1'b0, 1'b1, 4'h0, 32'h0);
    chk("in_read_only", dout, 32'h0);

    // Rise on bit 0 -> STAT then IRQ one edge later, then W1C
    step(1'b1, 1'b0, 4'h4, 32'h1);
    step(1'b1, 1'b0, 4'h7, 32'h1);
    gi[0] = 1'b1;
    for (int e = 1; e <= EV_EDGE + 1; e++) begin
      step(1'b0, 1'b1, 4'h6, 32'h0);
      if (e == EV_EDGE) begin
        chk("stat_pre_event", dout, 32'h0);
        chk("irq_at_stat_edge", 32'(irq), 32'h0);
      end
      if (e == EV_EDGE + 1) begin
        chk("stat_rise", dout, 32'h1);
        chk("irq_rise", 32'(irq), 32'h1);
      end
    end
    step(1'b1, 1'b0, 4'h6, 32'h1);
    chk("irq_clear_edge", 32'(irq), 32'h1);
    step(1'b0, 1'b0, 4'h0, 32'h0);
    chk("irq_cleared", 32'(irq), 32'h0);

    // Fall on bit 2 colliding with a W1C of the same bit
    step(1'b1, 1'b0, 4'h5, 32'h4);
    gi[2] = 1'b1;
    for (int e = 0; e < EV_EDGE + 2; e++) step(1'b0, 1'b0, 4'h0, 32'h0);
    gi[2] = 1'b0;
    for (int e = 0; e < EV_EDGE + 1; e++) step(1'b0, 1'b0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 4'h6, 32'h0);
    chk("stat_fall", dout & 32'h4, 32'h4);
    gi[2] = 1'b1;
    for (int e = 0; e < EV_EDGE + 2; e++) step(1'b0, 1'b0, 4'h0, 32'h0);
    gi[2] = 1'b0;
    for (int e = 1; e <= EV_EDGE; e++) begin
      if (e == EV_EDGE) step(1'b1, 1'b0, 4'h6, 32'h4);
      else step(1'b0, 1'b0, 4'h0, 32'h0);
    end
    step(1'b0, 1'b1, 4'h6, 32'h0);
    chk("event_beats_clear", dout & 32'h4, 32'h4);
    step(1'b1, 1'b0, 4'h5, 32'h0);
    step(1'b0, 1'b1, 4'h6, 32'h0);
    chk("en_change_keeps_stat", dout & 32'h4, 32'h4);
    step(1'b1, 1'b0, 4'h6, 32'h4);
    step(1'b0, 1'b1, 4'h6, 32'h0);
    chk("stat_w1c", dout & 32'h4, 32'h0);

    // Pin-to-IN latency on bit 1
    gi[1] = 1'b1;
    for (int e = 1; e <= EV_EDGE + 1; e++) begin
      step(1'b0, 1'b1, 4'h0, 32'h0);
      if (e == EV_EDGE) chk("in_latency_before", 32'(dout[1]), 32'h0);
      if (e == EV_EDGE + 1) chk("in_latency_after", 32'(dout[1]), 32'h1);
    end
    gi[1] = 1'b0;
    for (int e = 0; e < EV_EDGE + 2; e++) step(1'b0, 1'b0, 4'h0, 32'h0);

`ifdef OPB_GPIO_DEBOUNCE_EN
    // Short glitch must be filtered out
    gi[1] = 1'b1;
    for (int e = 0; e < 5; e++) step(1'b0, 1'b0, 4'h0, 32'h0);
    gi[1] = 1'b0;
    for (int e = 0; e < 25; e++) step(1'b0, 1'b0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 32'h0);
    chk("glitch_filtered", 32'(dout[1]), 32'h0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, TOGGLE_ODDS) == 0) begin
        k = $urandom_range(0, N_IN - 1);
        gi[k] = ~gi[k];
      end
      case ($urandom_range(0, 2))
        0: step(1'b0, 1'b0, 4'($urandom_range(0, 15)), $urandom());
        1: step(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom());
        default: step(1'b1, 1'b0, 4'($urandom_range(0, 7)), $urandom());
      endcase
    end

    // Asynchronous reset during a debounce count and a read
    step(1'b1, 1'b0, 4'h1, 32'h55);
    step(1'b1, 1'b0, 4'h7, 32'hFF);
    step(1'b1, 1'b0, 4'h4, 32'hFF);
    step(1'b1, 1'b0, 4'h5, 32'hFF);
    gi[3] = ~gi[3];
    for (int e = 0; e < EV_EDGE + 2; e++) step(1'b0, 1'b0, 4'h0, 32'h0);
    chk("pre_reset_irq", 32'(irq), 32'h1);
    gi[4] = ~gi[4];
    for (int e = 0; e < 4; e++) step(1'b0, 1'b0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 4'h1, 32'h0);
    chk("pre_reset_do", dout, 32'h55);
    re = 1'b1; addr = 32'h1;
    #2; rst = 1'b1; #1;
    chk("async_rst_do", dout, 32'h0);
    chk("async_rst_gpio_o", 32'(go), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    model_reset();
    @(posedge clk); #3; rst = 1'b0;
    step(1'b0, 1'b0, 4'h1, 32'h0);
    chk("no_stale_do", dout, 32'h0);
    for (int a = 1; a < 8; a++) begin
      step(1'b0, 1'b1, 4'(a), 32'h0);
      chk("post_rst_reg", dout, 32'h0);
    end
    for (int e = 0; e < EV_EDGE + 3; e++) step(1'b0, 1'b1, 4'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
